wb_commit_queue: RTL

WB_COMMIT_QUEUE -- requirements
Module: wb_commit_queue

---
 rtl/wb_commit_queue.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_commit_queue.sv
// wb_commit_queue: writeback-stage commit queue.
//
// Holds instructions leaving MEM in a circular FIFO and retires the head one per
// cycle. A normal head writes the register file. An exception or ERET head raises
// a one-cycle trap/return request toward CP0 together with a flush. The flush
// empties the whole queue at the next edge.
//
// Build option: define WB_COMMIT_FWD_EN to compile in the forwarding search, in
// which the youngest matching entry drives fwd_hit/fwd_data on each lookup port.
// Without it the forwarding outputs are tied to 0, and the queue accepts an entry
// only when it is empty, so it behaves as a single-entry stage.
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   ms_to_ws_valid / ws_allowin MEM handshake
//   ms_pc, ms_result, ms_badvaddr, ms_dest, ms_we, ms_eret, ms_slot,
//   ms_pc_error, ms_ex_code     entry payload
//   commit_stall                hold the head this cycle
//   rf_we, rf_waddr, rf_wdata   register-file write port
//   debug_wb_*                  trace outputs mirroring the head commit
//   ex_valid, ex_code, ex_epc, ex_slot, ex_badvaddr, eret   commit-time trap/return
//   flush                       pipeline flush request
//   fwd_raddr / fwd_hit / fwd_data  NUM_FWD forwarding lookup ports
//   count                       current occupancy
module wb_commit_queue #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned NUM_FWD = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   ms_to_ws_valid,
   output logic                   ws_allowin,
   input  logic [31:0]            ms_pc,
   input  logic [31:0]            ms_result,
   input  logic [31:0]            ms_badvaddr,
   input  logic [4:0]             ms_dest,
   input  logic                   ms_we,
   input  logic                   ms_eret,
   input  logic                   ms_slot,
   input  logic                   ms_pc_error,
   input  logic [4:0]             ms_ex_code,
   input  logic                   commit_stall,
   output logic                   rf_we,
   output logic [4:0]             rf_waddr,
   output logic [31:0]            rf_wdata,
   output logic [31:0]            debug_wb_pc,
   output logic [3:0]             debug_wb_rf_wen,
   output logic [4:0]             debug_wb_rf_wnum,
   output logic [31:0]            debug_wb_rf_wdata,
   output logic                   ex_valid,
   output logic [4:0]             ex_code,
   output logic [31:0]            ex_epc,
   output logic                   ex_slot,
   output logic [31:0]            ex_badvaddr,
   output logic                   eret,
   output logic                   flush,
   input  logic [NUM_FWD*5-1:0]   fwd_raddr,
   output logic [NUM_FWD-1:0]     fwd_hit,
   output logic [NUM_FWD*32-1:0]  fwd_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [4:0]  NoEx = 5'h00;

   // Payload storage, intentionally not reset.
   logic [31:0] pc_q       [DEPTH];
   logic [31:0] result_q   [DEPTH];
   logic [31:0] badvaddr_q [DEPTH];
   logic [4:0]  dest_q     [DEPTH];
   logic [4:0]  ex_code_q  [DEPTH];
   logic        we_q       [DEPTH];
   logic        eret_q     [DEPTH];
   logic        slot_q     [DEPTH];
   logic        pc_error_q [DEPTH];

   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic [CntW-1:0] count_q, count_d;

   logic head_vis;      // a valid head exists and reset is not forcing outputs low
   logic head_go;       // head is committed this cycle
   logic head_ex;
   logic head_eret;
   logic commit_flush;
   logic full;
   logic push;
   logic pop;

   always_comb begin
      head_vis     = !reset && (count_q != '0);
      head_go      = head_vis && !commit_stall;
      head_ex      = ex_code_q[head_q] != NoEx;
      // An exception outranks an ERET flag on the same entry.
      head_eret    = eret_q[head_q] && !head_ex;
      commit_flush = head_go && (head_ex || head_eret);
      full         = count_q == CntW'(DEPTH);
`ifdef WB_COMMIT_FWD_EN
      ws_allowin   = !reset && !full && !commit_flush;
`else
      ws_allowin   = !reset && !full && (count_q == '0) && !commit_flush;
`endif
      push         = ms_to_ws_valid && ws_allowin;
      pop          = head_go;
   end

   always_comb begin
      head_d  = head_q + PtrW'(pop);
      tail_d  = tail_q + PtrW'(push);
      count_d = count_q + CntW'(push) - CntW'(pop);
      // Push is already blocked while flushing, so dropping everything is exact.
      if (commit_flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_q[tail_q]       <= ms_pc;
         result_q[tail_q]   <= ms_result;
         badvaddr_q[tail_q] <= ms_badvaddr;
         dest_q[tail_q]     <= ms_dest;
         ex_code_q[tail_q]  <= ms_ex_code;
         we_q[tail_q]       <= ms_we;
         eret_q[tail_q]     <= ms_eret;
         slot_q[tail_q]     <= ms_slot;
         pc_error_q[tail_q] <= ms_pc_error;
      end
   end

   always_comb begin
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      debug_wb_pc = '0;
      ex_valid    = 1'b0;
      ex_code     = '0;
      ex_epc      = '0;
      ex_slot     = 1'b0;
      ex_badvaddr = '0;
      eret        = 1'b0;
      flush       = commit_flush;
      count       = reset ? '0 : count_q;
      if (head_vis) begin
         rf_waddr    = dest_q[head_q];
         rf_wdata    = result_q[head_q];
         debug_wb_pc = pc_q[head_q];
      end
      if (head_go) begin
         rf_we = we_q[head_q] && !head_ex && !head_eret;
         eret  = head_eret;
         if (head_ex) begin
            ex_valid    = 1'b1;
            ex_code     = ex_code_q[head_q];
            ex_epc      = pc_error_q[head_q] ? badvaddr_q[head_q] : pc_q[head_q];
            ex_slot     = slot_q[head_q];
            ex_badvaddr = badvaddr_q[head_q];
         end
      end
      debug_wb_rf_wen   = {4{rf_we}};
      debug_wb_rf_wnum  = rf_waddr;
      debug_wb_rf_wdata = rf_wdata;
   end

`ifdef WB_COMMIT_FWD_EN
   // Walk entries oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      logic [PtrW-1:0] idx;
      logic [4:0]      raddr;
      fwd_hit  = '0;
      fwd_data = '0;
      idx      = '0;
      raddr    = '0;
      for (int k = 0; k < NUM_FWD; k++) begin
         raddr = fwd_raddr[k*5 +: 5];
         for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if (!reset && (CntW'(i) < count_q) && (raddr != 5'd0) && we_q[idx] &&
                (ex_code_q[idx] == NoEx) && !eret_q[idx] && (dest_q[idx] == raddr)) begin
               fwd_hit[k]            = 1'b1;
               fwd_data[k*32 +: 32] = result_q[idx];
            end
         end
      end
   end
`else
   logic unused_fwd_raddr;
   assign unused_fwd_raddr = ^fwd_raddr;
   assign fwd_hit          = '0;
   assign fwd_data         = '0;
`endif

endmodule
